// File: rtl/nanov_reg_bridge_if.sv
// Bus bundle between a requester (load unit, debug, boot) and the nanoV register file bridge.
// The slave modport is the bridge; the master modport is the requester/register-file side.
interface nanov_reg_bridge_if #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 5
);
  logic             start;
  logic             write_req;
  logic [Width-1:0] wdata;
  logic [3:0]       wr_dest;
  logic [3:0]       rd_src;
  logic             data_rs;
  logic [3:0]       rs1;
  logic [3:0]       rd;
  logic             wr_en;
  logic             wr_next_en;
  logic             data_rd;
  logic             data_rd_next;
  logic [Width-1:0] rdata;
  logic             busy;
  logic             done;
  logic [CntW-1:0]  phase;

  modport master (
    output start, write_req, wdata, wr_dest, rd_src, data_rs,
    input  rs1, rd, wr_en, wr_next_en, data_rd, data_rd_next, rdata, busy, done, phase
  );

  modport slave (
    input  start, write_req, wdata, wr_dest, rd_src, data_rs,
    output rs1, rd, wr_en, wr_next_en, data_rd, data_rd_next, rdata, busy, done, phase
  );
endinterface

// File: rtl/nanov_reg_bridge.sv
// Parallel/serial bridge to the nanoV bit-serial register file: writes one word LSB-first
// and captures one serial read stream, always aligned to the file's free-running bit phase.
module nanov_reg_bridge #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 5
) (
  input logic               clk_i,
  input logic               rst_ni,
  nanov_reg_bridge_if.slave bus
);

  localparam logic [CntW-1:0] LastPhase = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  phase_q;
  logic [Width-1:0] word_q;
  logic [Width-1:0] rdata_q;
  logic [3:0]       dest_q;
  logic [3:0]       src_q;
  logic             write_q;
  logic             last_bit;
  logic             capture;
  logic             xfer_we;

  assign last_bit = (phase_q == LastPhase);
  assign capture  = (state_q == StIdle) && bus.start;
  assign xfer_we  = write_q && (dest_q != 4'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = last_bit ? StXfer : StWait;
      StWait: if (last_bit) state_d = StXfer;
      StXfer: if (last_bit) state_d = StDone;
      StDone: state_d = StIdle;
    endcase
  end

  // Write word shifts out LSB-first with zeros behind it, so word_q[1] is the look-ahead bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      dest_q  <= '0;
      src_q   <= '0;
      write_q <= 1'b0;
    end else begin
      phase_q <= last_bit ? '0 : phase_q + CntW'(1);
      if (capture) begin
        word_q  <= bus.wdata;
        dest_q  <= bus.wr_dest;
        src_q   <= bus.rd_src;
        write_q <= bus.write_req;
      end else if (state_q == StXfer) begin
        word_q  <= word_q >> 1;
        rdata_q <= {bus.data_rs, rdata_q[Width-1:1]};
      end
    end
  end

  always_comb begin
    bus.rs1          = 4'd0;
    bus.rd           = 4'd0;
    bus.wr_en        = 1'b0;
    bus.wr_next_en   = 1'b0;
    bus.data_rd      = 1'b0;
    bus.data_rd_next = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.rdata        = rdata_q;
    bus.phase        = phase_q;
    unique case (state_q)
      StIdle: ;
      StWait: begin
        bus.busy = 1'b1;
        bus.rs1  = src_q;
        bus.rd   = dest_q;
      end
      StXfer: begin
        bus.busy         = 1'b1;
        bus.rs1          = src_q;
        bus.rd           = dest_q;
        bus.data_rd      = word_q[0];
        bus.data_rd_next = last_bit ? 1'b0 : word_q[1];
        bus.wr_en        = xfer_we;
        bus.wr_next_en   = xfer_we && !last_bit;
      end
      StDone: bus.done = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_nanov_reg_bridge.sv
// Scoreboard bench for nanov_reg_bridge: stimulus pushes expected transfers, a negedge
// monitor checks every cycle against a cycle-count model of phase and transfer timing.
module tb_nanov_reg_bridge;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  nanov_reg_bridge_if #(.Width(32), .CntW(5)) bus ();

  nanov_reg_bridge #(.Width(32), .CntW(5)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  typedef struct {
    int          c;
    int          x;
    bit          wr;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [31:0] wd;
    logic [31:0] rdv;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] rf [16];
  int          cyc;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rdata = '0;
  bit          fin = 1'b0;

  // Static register-file model feeding the serial read port.
  assign bus.data_rs = rf[bus.rs1][bus.phase];

  // Cycles since reset release; the model's phase is this count mod 32.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  txn_t mt;
  int   mk;
  bit   mwe;

  always @(negedge clk) begin
    if (rst_ni && !fin) begin
      chk("phase", 64'(bus.phase), 64'(cyc % 32));
      if (sb.size() > 0 && cyc > sb[0].c) begin
        mt = sb[0];
        if (cyc < mt.x) begin
          chk("wait_busy", 64'(bus.busy), 64'(1));
          chk("wait_done", 64'(bus.done), 64'(0));
          chk("wait_rd", 64'(bus.rd), 64'(mt.dst));
          chk("wait_rs1", 64'(bus.rs1), 64'(mt.src));
          chk("wait_serial", 64'({bus.data_rd, bus.data_rd_next, bus.wr_en, bus.wr_next_en}),
              64'(0));
          chk("wait_rdata", 64'(bus.rdata), 64'(last_rdata));
        end else if (cyc < mt.x + 32) begin
          mk  = cyc - mt.x;
          mwe = mt.wr && (mt.dst != 4'd0);
          chk("xfer_busy", 64'(bus.busy), 64'(1));
          chk("xfer_done", 64'(bus.done), 64'(0));
          chk("xfer_rd", 64'(bus.rd), 64'(mt.dst));
          chk("xfer_rs1", 64'(bus.rs1), 64'(mt.src));
          chk("data_rd", 64'(bus.data_rd), 64'(mt.wd[mk]));
          chk("data_rd_next", 64'(bus.data_rd_next), 64'((mk < 31) ? mt.wd[mk+1] : 1'b0));
          chk("wr_en", 64'(bus.wr_en), 64'(mwe));
          chk("wr_next_en", 64'(bus.wr_next_en), 64'(mwe && (mk < 31)));
        end else begin
          chk("done_pulse", 64'(bus.done), 64'(1));
          chk("done_busy", 64'(bus.busy), 64'(0));
          chk("done_sel", 64'({bus.rd, bus.rs1}), 64'(0));
          chk("done_serial", 64'({bus.data_rd, bus.data_rd_next, bus.wr_en, bus.wr_next_en}),
              64'(0));
          chk("rdata", 64'(bus.rdata), 64'(mt.rdv));
          last_rdata = mt.rdv;
          void'(sb.pop_front());
        end
      end else begin
        chk("idle_busy", 64'(bus.busy), 64'(0));
        chk("idle_done", 64'(bus.done), 64'(0));
        chk("idle_sel", 64'({bus.rd, bus.rs1}), 64'(0));
        chk("idle_serial", 64'({bus.data_rd, bus.data_rd_next, bus.wr_en, bus.wr_next_en}),
            64'(0));
        chk("idle_rdata", 64'(bus.rdata), 64'(last_rdata));
      end
    end
  end

  task automatic scramble();
    bus.write_req = 1'($urandom);
    bus.wdata     = $urandom;
    bus.wr_dest   = 4'($urandom);
    bus.rd_src    = 4'($urandom);
  endtask

  // Issue one transfer once the model says the bridge is idle; ph<0 means any phase.
  task automatic issue(bit wr, logic [3:0] dst, logic [3:0] src, logic [31:0] wd, int ph);
    txn_t t;
    while (sb.size() != 0) @(negedge clk);
    @(negedge clk);
    if (ph >= 0) while ((cyc % 32) != ph) @(negedge clk);
    bus.start     = 1'b1;
    bus.write_req = wr;
    bus.wr_dest   = dst;
    bus.rd_src    = src;
    bus.wdata     = wd;
    t.c   = cyc;
    t.x   = cyc + 32 - (cyc % 32);
    t.wr  = wr;
    t.dst = dst;
    t.src = src;
    t.wd  = wd;
    t.rdv = rf[src];
    sb.push_back(t);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
  endtask

  // Extra start pulses with fresh data while a transfer is pending; all must be ignored.
  task automatic noise();
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
      bus.start = (cyc < sb[0].x + 32) && ($urandom_range(0, 2) == 0);
      scramble();
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    while (sb.size() != 0) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    rf[0] = '0;
    rf[5] = 32'h1234_5678;
    bus.start = 1'b0;
    scramble();

    #12;
    chk("rst_phase", 64'(bus.phase), 64'(0));
    chk("rst_rdata", 64'(bus.rdata), 64'(0));
    chk("rst_ctrl", 64'({bus.busy, bus.done, bus.rd, bus.rs1}), 64'(0));
    chk("rst_serial", 64'({bus.data_rd, bus.data_rd_next, bus.wr_en, bus.wr_next_en}), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;

    issue(1'b1, 4'd3, 4'd0, 32'hDEAD_BEEF, 5);
    issue(1'b0, 4'd7, 4'd5, $urandom, -1);
    issue(1'b1, 4'd9, 4'd2, $urandom, 31);
    issue(1'b1, 4'd4, 4'd6, 32'hA5A5_0F0F, 3);
    noise();
    issue(1'b1, 4'd12, 4'd1, 32'hCAFE_F00D, 20);
    noise();

    // Reset at XFER bit 10: outputs drop immediately, no done pulse afterwards.
    issue(1'b1, 4'd11, 4'd8, $urandom, -1);
    while (cyc != sb[0].x + 10) @(negedge clk);
    #2;
    rst_ni = 1'b0;
    sb.delete();
    last_rdata = '0;
    #1;
    chk("midrst_phase", 64'(bus.phase), 64'(0));
    chk("midrst_rdata", 64'(bus.rdata), 64'(0));
    chk("midrst_ctrl", 64'({bus.busy, bus.done, bus.rd, bus.rs1}), 64'(0));
    chk("midrst_serial", 64'({bus.data_rd, bus.data_rd_next, bus.wr_en, bus.wr_next_en}),
        64'(0));
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    issue(1'b1, 4'd0, 4'd5, 32'hFFFF_FFFF, -1);
    for (int n = 0; n < 16; n++) begin
      issue(1'($urandom), 4'($urandom), 4'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 1) noise();
    end
    wait_idle();
    repeat (3) @(negedge clk);
    fin = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
